// File: rtl/instr_stream_packer.sv
// ============================================================================
// Module   : instr_stream_packer
// Purpose  : Packs 16/32-bit RISC-V instructions into aligned 32-bit fetch words.
//            Optional INSTR_PACKER_DRAIN_EN pads a pending halfword with c.nop.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_stream_packer #(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(64'h8000_0000)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] flush_addr_i,
    input  logic [31:0]           instr_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic                  drain_i,
    output logic [31:0]           fetch_rdata_o,
    output logic [ADDR_WIDTH-1:0] fetch_addr_o,
    output logic                  fetch_valid_o,
    input  logic                  fetch_ready_i
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    state_t                r_state;
    logic [15:0]           r_res;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [31:0]           r_rdata;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_valid;

    logic                  w_is_c;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_emit;
    logic [31:0]           w_word;
    state_t                w_state_nxt;
    logic [15:0]           w_res_nxt;
    logic                  w_unused;

    always_comb begin
        w_is_c      = (instr_i[1:0] != 2'b11);
        w_ready     = ~flush_i & (~r_valid | fetch_ready_i);
        w_accept    = instr_valid_i & w_ready;
        w_emit      = 1'b0;
        w_word      = instr_i;
        w_state_nxt = r_state;
        w_res_nxt   = r_res;

        if (w_accept) begin
            if (r_state == S_EMPTY) begin
                if (w_is_c) begin
                    w_res_nxt   = instr_i[15:0];
                    w_state_nxt = S_HALF;
                end else begin
                    w_emit = 1'b1;
                    w_word = instr_i;
                end
            end else begin
                // The pending halfword always forms the low half of the next word.
                w_emit = 1'b1;
                w_word = {instr_i[15:0], r_res};
                if (w_is_c) begin
                    w_state_nxt = S_EMPTY;
                end else begin
                    w_res_nxt = instr_i[31:16];
                end
            end
        end
`ifdef INSTR_PACKER_DRAIN_EN
        else if (drain_i && !instr_valid_i && w_ready && (r_state == S_HALF)) begin
            w_emit      = 1'b1;
            w_word      = {16'h0001, r_res};
            w_state_nxt = S_EMPTY;
        end
`endif
    end

`ifdef INSTR_PACKER_DRAIN_EN
    assign w_unused = ^flush_addr_i[1:0];
`else
    assign w_unused = ^{flush_addr_i[1:0], drain_i};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_EMPTY;
            r_res       <= 16'h0000;
            r_next_addr <= RESET_ADDR;
            r_rdata     <= 32'h0000_0000;
            r_addr      <= '0;
            r_valid     <= 1'b0;
        end else if (flush_i) begin
            r_state     <= S_EMPTY;
            r_next_addr <= {flush_addr_i[ADDR_WIDTH-1:2], 2'b00};
            r_valid     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_res   <= w_res_nxt;
            if (w_emit) begin
                r_rdata     <= w_word;
                r_addr      <= r_next_addr;
                r_next_addr <= r_next_addr + ADDR_WIDTH'(4);
                r_valid     <= 1'b1;
            end else if (fetch_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign instr_ready_o = w_ready;
    assign fetch_rdata_o = r_rdata;
    assign fetch_addr_o  = r_addr;
    assign fetch_valid_o = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_instr_stream_packer.sv
// ============================================================================
// Module   : tb_instr_stream_packer
// Purpose  : Scoreboard bench for instr_stream_packer (default and wrap builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_stream_packer;

    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic [63:0] flush_addr_i;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        drain_i;
    logic [31:0] fetch_rdata_o;
    logic [63:0] fetch_addr_o;
    logic        fetch_valid_o;
    logic        fetch_ready_i;

    logic        wrap_en;
    logic        w2_valid_in;
    logic        w2_ready;
    logic [31:0] w2_rdata;
    logic [63:0] w2_addr;
    logic        w2_valid;

    int          n_tests = 0;
    int          n_fail  = 0;
    item_t       sb[$];

    logic        m_half;
    logic        m_valid;
    logic [15:0] m_res;
    logic [63:0] m_naddr;
    logic        last_acc;
    logic [63:0] exp2;
    int          n_w2;

    always #5 clk = ~clk;

    assign w2_valid_in = instr_valid_i & wrap_en;

    instr_stream_packer #(.ADDR_WIDTH(64), .RESET_ADDR(64'h8000_0000)) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .flush_addr_i (flush_addr_i),
        .instr_i      (instr_i),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .drain_i      (drain_i),
        .fetch_rdata_o(fetch_rdata_o),
        .fetch_addr_o (fetch_addr_o),
        .fetch_valid_o(fetch_valid_o),
        .fetch_ready_i(fetch_ready_i)
    );

    instr_stream_packer #(.ADDR_WIDTH(64), .RESET_ADDR(64'hFFFF_FFFF_FFFF_FFFC)) u_dut_wrap (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (1'b0),
        .flush_addr_i (64'h0),
        .instr_i      (instr_i),
        .instr_valid_i(w2_valid_in),
        .instr_ready_o(w2_ready),
        .drain_i      (1'b0),
        .fetch_rdata_o(w2_rdata),
        .fetch_addr_o (w2_addr),
        .fetch_valid_o(w2_valid),
        .fetch_ready_i(1'b1)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_half  = 1'b0;
        m_valid = 1'b0;
        m_res   = 16'h0;
        m_naddr = 64'h8000_0000;
        sb.delete();
    endtask

    // One clock cycle: entered just after a falling edge, leaves at the next one.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic fr,
                       input logic fl, input logic [63:0] fa, input logic dr);
        logic        exp_ready;
        logic        emit;
        logic [31:0] word;
        item_t       it;
        instr_valid_i = v;
        instr_i       = ins;
        fetch_ready_i = fr;
        flush_i       = fl;
        flush_addr_i  = fa;
        drain_i       = dr;
        #1;
        exp_ready = !fl && (!m_valid || fr);
        check("instr_ready", instr_ready_o, exp_ready);
        check("fetch_valid", fetch_valid_o, m_valid);
        if (fetch_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 64'(fetch_rdata_o), 64'hDEAD_0000_0000_0000);
            end else begin
                check("rdata", fetch_rdata_o, sb[0].d);
                check("addr", fetch_addr_o, sb[0].a);
                if (fr) it = sb.pop_front();
            end
        end
        if (w2_valid) begin
            check("wrap_addr", w2_addr, exp2);
            exp2 = exp2 + 64'd4;
            n_w2++;
        end
        last_acc = v && exp_ready;
        emit = 1'b0;
        word = 32'h0;
        if (fl) begin
            m_half  = 1'b0;
            m_valid = 1'b0;
            m_naddr = {fa[63:2], 2'b00};
            sb.delete();
        end else begin
            if (last_acc) begin
                if (!m_half) begin
                    if (ins[1:0] != 2'b11) begin
                        m_res  = ins[15:0];
                        m_half = 1'b1;
                    end else begin
                        emit = 1'b1;
                        word = ins;
                    end
                end else begin
                    emit = 1'b1;
                    word = {ins[15:0], m_res};
                    if (ins[1:0] != 2'b11) m_half = 1'b0;
                    else m_res = ins[31:16];
                end
            end
`ifdef INSTR_PACKER_DRAIN_EN
            else if (dr && m_half && !v && exp_ready) begin
                emit   = 1'b1;
                word   = {16'h0001, m_res};
                m_half = 1'b0;
            end
`endif
            if (emit) begin
                sb.push_back('{a: m_naddr, d: word});
                m_naddr = m_naddr + 64'd4;
                m_valid = 1'b1;
            end else if (fr) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] ins);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, ins, 1'b1, 1'b0, 64'h0, 1'b0);
            if (last_acc) return;
        end
        check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; flush_addr_i = 64'h0; instr_i = 32'h0;
        instr_valid_i = 1'b0; drain_i = 1'b0; fetch_ready_i = 1'b1; wrap_en = 1'b0;
        exp2 = 64'hFFFF_FFFF_FFFF_FFFC; n_w2 = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_valid", fetch_valid_o, 1'b0);
        check("rst_rdata", fetch_rdata_o, 32'h0);
        check("rst_addr", fetch_addr_o, 64'h0);
        check("rst_ready", instr_ready_o, 1'b1);
        @(negedge clk);
        rst_ni = 1'b1;

        // Four 32-bit words, also driven into the wrap instance.
        wrap_en = 1'b1;
        send(32'h0000_0013); send(32'h0010_0093); send(32'h0020_0113); send(32'h0030_0193);
        wrap_en = 1'b0;
        idle(2);
        check("wrap_count", 64'(n_w2), 64'd4);

        // Reset asserted mid-stream with a word pending.
        send(32'h0000_4501); send(32'h00A0_0593);
        instr_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", fetch_valid_o, 1'b0);
        check("async_rst_rdata", fetch_rdata_o, 32'h0);
        check("async_rst_addr", fetch_addr_o, 64'h0);
        check("async_rst_ready", instr_ready_o, 1'b1);
        model_reset();
        exp2 = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        rst_ni = 1'b1;
        idle(1);

        // Compressed / straddling mix.
        send(32'h0000_4501); send(32'h00A0_0593); send(32'h0000_8082);
        idle(2);

        // Backpressure with an instruction waiting.
        send(32'h0000_0013);
        for (int k = 0; k < 5; k++) cyc(1'b1, 32'h0010_0093, 1'b0, 1'b0, 64'h0, 1'b0);
        send(32'h0010_0093);
        idle(2);

        // Flush while a halfword is pending.
        send(32'h0000_4501);
        cyc(1'b1, 32'h0000_4601, 1'b1, 1'b1, 64'h0000_0000_8000_0106, 1'b0);
        send(32'h0000_0013);
        idle(2);

        // Drain request with a pending halfword.
        send(32'h0000_4501);
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);

        // Address wrap, then back-to-back compressed and straddling chains.
        send(32'h0000_0013); send(32'h0010_0093);
        send(32'h0000_4501); send(32'h0000_4502); send(32'h0000_4503); send(32'h0000_4504);
        send(32'h0000_0001); send(32'h1234_5677); send(32'hABCD_EF13); send(32'h0000_8082);
        idle(3);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_stream_packer.md
# instr_stream_packer

- Packs a stream of individual RISC-V instructions into aligned 32-bit fetch words. Instructions are 16-bit compressed or 32-bit; 32-bit instructions may straddle two words.
- Transmitter side of the fetch-word interface: acts as the instruction-memory/ICache model driving the fetch FIFO in block-level benches and FPGA bring-up.
- A single 16-bit residue register and a one-entry output register implement the packing.

## Interface

Parameters:
- ADDR_WIDTH, default 64: fetch address width.
- RESET_ADDR, default 64'h8000_0000: address of the first fetch word after reset; must be 4-byte aligned.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. Asynchronous, active-low.
- flush_i  in  1  discard residue and output word; restart at flush_addr_i.
- flush_addr_i  in  ADDR_WIDTH  restart address; bits [1:0] ignored (treated as 0).
- instr_i  in  32  instruction; compressed when instr_i[1:0] != 2'b11, then only [15:0] is used.
- instr_valid_i  in  1  instruction available.
- instr_ready_o  out  1  instruction accepted when valid&&ready.
- drain_i  in  1  pad pending residue to a full word (see Configuration).
- fetch_rdata_o  out  32  packed fetch word.
- fetch_addr_o  out  ADDR_WIDTH  address of fetch_rdata_o; always 4-aligned.
- fetch_valid_o  out  1  fetch word valid.
- fetch_ready_i  in  1  consumer accepts the word when valid&&ready.

## Operation

- Two-state FSM on residue occupancy:
  - EMPTY: no pending halfword.
  - HALF: res_q[15:0] holds the low halfword of the next word.
- Transfers on an accepted instruction:
  - EMPTY + compressed: res_q = instr[15:0]; go to HALF; no word emitted.
  - EMPTY + 32-bit: emit instr[31:0]; stay in EMPTY.
  - HALF + compressed: emit {instr[15:0], res_q}; go to EMPTY.
  - HALF + 32-bit: emit {instr[15:0], res_q}; res_q = instr[31:16]; stay in HALF.
- Emitting a word loads the output register:
  - fetch_rdata_o gets the packed word.
  - fetch_addr_o gets next_addr_q.
  - next_addr_q increments by 4, modulo 2^ADDR_WIDTH (wraps silently).
- instr_ready_o = ~fetch_valid_o | fetch_ready_i, combinational. This holds even for transfers that emit nothing.
- Output register behaviour:
  - fetch_valid_o clears when the word is taken and no new word is emitted in that cycle.
  - fetch_rdata_o and fetch_addr_o hold stable while valid && !ready.
- flush_i has priority over everything else in its cycle:
  - FSM goes to EMPTY.
  - fetch_valid_o = 0 next cycle.
  - next_addr_q = {flush_addr_i[ADDR_WIDTH-1:2], 2'b00}.
  - instr_ready_o is forced to 0 during flush.
  - An instruction presented in that cycle is not accepted.
- Reset values:
  - FSM = EMPTY; res_q = 0; next_addr_q = RESET_ADDR.
  - fetch_valid_o = 0, fetch_rdata_o = 0, fetch_addr_o = 0.
  - instr_ready_o = 1 (combinational from fetch_valid_o = 0).

## Timing

- Latency: one cycle from the accepting edge of the completing instruction to fetch_valid_o = 1.
- Throughput:
  - One word per cycle for back-to-back 32-bit instructions, in either state.
  - One word per two cycles for back-to-back compressed instructions.
- Simultaneous events:
  - fetch_ready_i && instr_valid_i with an emitting transfer: the output register reloads in the same edge; no bubble.
- Reset assertion mid-stream:
  - Outputs take their reset values immediately (asynchronously).
  - No partial word is emitted after deassertion.
- Backpressure: with fetch_ready_i = 0 and fetch_valid_o = 1, instr_ready_o = 0, residue is frozen, and no instruction is lost.

## Configuration

- Macro: INSTR_PACKER_DRAIN_EN.
- Defined:
  - drain_i is honoured only in state HALF when instr_valid_i = 0 (an accepted instruction wins).
  - If instr_ready_o is also high, the block emits {16'h0001, res_q} (c.nop pad) and goes to EMPTY.
  - next_addr_q advances by 4 as for any emitted word.
- Undefined:
  - drain_i is ignored.
  - The residue stays pending until the next instruction arrives.

## Test plan

- Reset, then four 32-bit instructions 0x00000013, 0x00100093, 0x00200113, 0x00300193 with ready=1 → words equal to the inputs at addresses 0x8000_0000/04/08/0C on four consecutive cycles.
- Compressed 0x4501 then 32-bit 0x00A00593 → word 0x0593_4501 @0x8000_0000. Residue 0x00A0 stays pending in HALF, so a following compressed 0x8082 → word 0x8082_00A0 @0x8000_0004.
- Hold fetch_ready_i=0 for 5 cycles with a valid word → fetch_rdata_o and fetch_addr_o stable, instr_ready_o=0. Releasing ready → word taken once, no duplicate and no loss.
- In HALF with residue 0x4501, assert flush_i with flush_addr_i=0x8000_0106 → next word address 0x8000_0104; the residue is never emitted.
- INSTR_PACKER_DRAIN_EN defined, residue 0x4501, drain_i=1 → word 0x0001_4501. Undefined → no word, and fetch_valid_o stays 0.
- RESET_ADDR=64'hFFFF_FFFF_FFFF_FFFC, two 32-bit instructions → addresses 0xFFFF_FFFF_FFFF_FFFC then 0x0.
